// File: rtl/hilo_pkg.sv
// Shared encodings and small decode helpers for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on a shared 2*WIDTH accumulator: shift-add for multiply,
// restoring shift-subtract for divide (upper half = remainder, lower half = quotient).
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     m_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? m_i : {WIDTH{1'b0}})};
    shifted = acc_i[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, m_i};
    acc_o   = {sum, acc_i[WIDTH-1:1]};
    if (div_i) begin
      // Borrow out of the trial subtraction means the divisor did not fit: restore.
      if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      else              acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative multiply/divide sequencer (IDLE -> CALC -> FIX).
// Start is taken only while Busy=0; Done pulses for one cycle on every HI/LO write.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [2:0]        Op,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              Cancel,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  Hi,
  output logic [WIDTH-1:0]  Lo,
  output state_e            dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 op_div;
  logic [2*WIDTH-1:0]   step_acc;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quot_s, rem_s;
  logic [2*WIDTH-1:0]   fix_val;

  assign a_neg  = is_signed(Op) & A[WIDTH-1];
  assign b_neg  = is_signed(Op) & B[WIDTH-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign op_div = is_div(op_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (op_div),
    .acc_i (acc_q),
    .m_i   (m_q),
    .acc_o (step_acc)
  );

  // Sign correction and HI/LO result selection, consumed only in FIX.
  always_comb begin
    prod_s = qneg_q ? -acc_q : acc_q;
    quot_s = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_s  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MADD:         fix_val = {hi_q, lo_q} + prod_s;
      OP_MSUB:         fix_val = {hi_q, lo_q} - prod_s;
      OP_DIV, OP_DIVU: fix_val = (m_q == '0) ? {rem_s, {WIDTH{1'b1}}} : {rem_s, quot_s};
      default:         fix_val = prod_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    m_d     = m_q;
    acc_d   = acc_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (Op)
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            default: begin
              op_d    = Op;
              // Multiply iterates over the multiplier in the low half; divide shifts the dividend out of it.
              m_d     = is_div(Op) ? b_mag : a_mag;
              acc_d   = {{WIDTH{1'b0}}, (is_div(Op) ? a_mag : b_mag)};
              qneg_d  = a_neg ^ b_neg;
              rneg_d  = a_neg;
              cnt_d   = CNT_W'(WIDTH);
              state_d = CALC;
            end
          endcase
        end
      end
      CALC: begin
        if (Cancel) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!Cancel) begin
          hi_d   = fix_val[2*WIDTH-1:WIDTH];
          lo_d   = fix_val[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign Hi          = hi_q;
  assign Lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule
